vga_fb_reader: RTL and testbench

VGA_FB_READER -- requirements
Module: vga_fb_reader

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_pix_fifo.sv | 59 +++++
 rtl/vga_fb_reader.sv | 145 ++++++++++++++
 tb/tb_vga_fb_reader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA framebuffer reader: frame geometry,
// FSM states, the RGB565 word layout and its expansion to 8-bit channels.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FB_WORDS     = H_ACTIVE_DEF * V_ACTIVE_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fb_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Replicating the top bits keeps full-scale inputs at full scale (1F -> FF).
  function automatic logic [23:0] expand_565(input rgb565_t px);
    return {px.r, px.r[4:2], px.g, px.g[5:4], px.b, px.b[4:2]};
  endfunction

endpackage

// File: rtl/vga_pix_fifo.sv
// Synchronous pixel prefetch FIFO (16-bit words, power-of-two depth) with a
// flush that overrides any push or pop in the same cycle.
module vga_pix_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [15:0]              i_wdata,
  input  logic                     i_pop,
  output logic [15:0]              o_rdata,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~w_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer reader: prefetches one frame of RGB565 words from SRAM into a
// FIFO and serves pixels to the VGA stage. VGA_FB_UNDERFLOW_CNT_EN adds a
// saturating count of underflowing pops on o_underflow_cnt.
//
// state  | meaning
// IDLE   | after reset; nothing fetched until sof
// FETCH  | requesting frame words while the FIFO has room
// DONE   | whole frame fetched; waiting for the next sof
module vga_fb_reader
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sof,
  input  logic [19:0] i_fb_base,
  input  logic        i_pix_rd,
  output logic [7:0]  o_pix_r,
  output logic [7:0]  o_pix_g,
  output logic [7:0]  o_pix_b,
  output logic        o_underflow,
  output logic        o_mem_req,
  output logic [19:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata
`ifdef VGA_FB_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] o_underflow_cnt
`endif
);

  localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;
  localparam int REM_W = $clog2(((FRAME_WORDS > FB_WORDS) ? FRAME_WORDS : FB_WORDS) + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  fb_state_e        r_state;
  logic             r_mem_req;
  logic [19:0]      r_mem_addr;
  logic [REM_W-1:0] r_remaining;
  logic [23:0]      r_pix;
  logic             r_underflow;

  logic [CNT_W-1:0] w_fifo_count;
  logic [15:0]      w_fifo_rdata;
  logic             w_fifo_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_uf_pop;
  logic [CNT_W-1:0] w_count_nxt;
  logic [REM_W-1:0] w_rem_nxt;

  // sof flushes, so an ack or pop landing on it is dropped.
  assign w_push   = r_mem_req & i_mem_ack & ~i_sof;
  assign w_pop    = i_pix_rd & ~w_fifo_empty & ~i_sof;
  assign w_uf_pop = i_pix_rd & w_fifo_empty & ~i_sof;

  vga_pix_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_sof),
    .i_push  (w_push),
    .i_wdata (i_mem_rdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_count_nxt = w_fifo_count;
    if (w_push && !w_pop)      w_count_nxt = w_fifo_count + 1'b1;
    else if (w_pop && !w_push) w_count_nxt = w_fifo_count - 1'b1;
  end

  assign w_rem_nxt = w_push ? (r_remaining - 1'b1) : r_remaining;

  // The request is registered against next-cycle occupancy, so it already
  // matches "room and words left" in the cycle it is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_remaining <= '0;
    end else if (i_sof) begin
      r_state     <= ST_FETCH;
      r_mem_req   <= 1'b1;
      r_mem_addr  <= i_fb_base;
      r_remaining <= REM_INIT;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_push) begin
            r_mem_addr  <= r_mem_addr + 1'b1;
            r_remaining <= w_rem_nxt;
          end
          r_mem_req <= (w_count_nxt < CNT_FULL) && (w_rem_nxt != '0);
          if (w_rem_nxt == '0) r_state <= ST_DONE;
        end
        default: r_mem_req <= 1'b0;
      endcase
    end
  end

  assign o_mem_req  = r_mem_req & ~i_sof;
  assign o_mem_addr = r_mem_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix       <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_pix <= w_pop ? expand_565(rgb565_t'(w_fifo_rdata)) : 24'h0;
      if (i_sof)         r_underflow <= 1'b0;
      else if (w_uf_pop) r_underflow <= 1'b1;
    end
  end

  assign o_pix_r     = r_pix[23:16];
  assign o_pix_g     = r_pix[15:8];
  assign o_pix_b     = r_pix[7:0];
  assign o_underflow = r_underflow;

`ifdef VGA_FB_UNDERFLOW_CNT_EN
  logic [15:0] r_uf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_uf_cnt <= '0;
    else if (i_sof)                            r_uf_cnt <= '0;
    else if (w_uf_pop && r_uf_cnt != 16'hFFFF) r_uf_cnt <= r_uf_cnt + 16'd1;
  end

  assign o_underflow_cnt = r_uf_cnt;
`else
  // Without the counter, underflow events only reach the sticky flag.
`endif

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: queue-based reference model checked every cycle,
// a colour table, and hand sequences for fill, underflow, flush and wrap.
module tb_vga_fb_reader;
  import vga_pkg::*;

  localparam int DEPTH = 16;
  localparam int H     = 16;
  localparam int V     = 4;
  localparam int WORDS = H * V;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_sof;
  logic [19:0] i_fb_base;
  logic        i_pix_rd;
  logic [7:0]  o_pix_r, o_pix_g, o_pix_b;
  logic        o_underflow;
  logic        o_mem_req;
  logic [19:0] o_mem_addr;
  logic        i_mem_ack;
  logic [15:0] i_mem_rdata;
`ifdef VGA_FB_UNDERFLOW_CNT_EN
  logic [15:0] o_underflow_cnt;
`endif

  always #5 clk = ~clk;

  vga_fb_reader #(.FIFO_DEPTH(DEPTH), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sof       (i_sof),
    .i_fb_base   (i_fb_base),
    .i_pix_rd    (i_pix_rd),
    .o_pix_r     (o_pix_r),
    .o_pix_g     (o_pix_g),
    .o_pix_b     (o_pix_b),
    .o_underflow (o_underflow),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ack   (i_mem_ack),
`ifdef VGA_FB_UNDERFLOW_CNT_EN
    .o_underflow_cnt (o_underflow_cnt),
`endif
    .i_mem_rdata (i_mem_rdata)
  );

  typedef struct {
    logic [15:0] word;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } pix_vec_t;

  pix_vec_t    tbl [6];
  logic [19:0] exp_wrap [4];

  int n_vec = 0;
  int n_err = 0;

  // reference model
  bit          m_fetch;
  logic [15:0] m_q [$];
  logic [19:0] m_addr;
  int          m_rem;
  bit          m_uf;
  logic [23:0] m_pix;
  int          m_ucnt;

  // SRAM responder
  logic [15:0] sram [logic [19:0]];
  int          ack_wait;
  int          req_age;
  bit          rnd_wait;
  int          n_xfer;
  logic [19:0] xfer_addr [$];

  function automatic logic [23:0] ref_expand(input logic [15:0] w);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(w[15:11]);
    g6 = int'(w[10:5]);
    b5 = int'(w[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return 24'(r8 * 65536 + g8 * 256 + b8);
  endfunction

  function automatic logic [15:0] sram_word(input logic [19:0] a);
    if (sram.exists(a)) return sram[a];
    return a[15:0] ^ {a[19:16], 12'h5A3};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetch = 1'b0;
    m_q.delete();
    m_addr  = '0;
    m_rem   = 0;
    m_uf    = 1'b0;
    m_pix   = '0;
    m_ucnt  = 0;
    req_age = 0;
  endtask

  // One clock: drive at negedge, check, advance the model, wait next negedge.
  task automatic cycle(input bit sof, input logic [19:0] base, input bit rd, input bit ack_force);
    bit          exp_req;
    bit          ack;
    logic [15:0] rdata;
    exp_req = m_fetch && (m_q.size() < DEPTH) && (m_rem > 0) && !sof;
    ack     = (exp_req && req_age >= ack_wait) || ack_force;
    rdata   = sram_word(m_addr);
    i_sof       = sof;
    i_fb_base   = base;
    i_pix_rd    = rd;
    i_mem_ack   = ack;
    i_mem_rdata = rdata;
    #1;
    chk("mem_req", 32'(o_mem_req), 32'(exp_req));
    chk("mem_addr", 32'(o_mem_addr), 32'(m_addr));
    chk("pix", 32'({o_pix_r, o_pix_g, o_pix_b}), 32'(m_pix));
    chk("underflow", 32'(o_underflow), 32'(m_uf));
`ifdef VGA_FB_UNDERFLOW_CNT_EN
    chk("underflow_cnt", 32'(o_underflow_cnt), 32'(m_ucnt));
`endif
    if (o_mem_req && i_mem_ack) begin
      n_xfer++;
      xfer_addr.push_back(o_mem_addr);
    end
    if (sof) begin
      m_q.delete();
      m_addr  = base;
      m_rem   = WORDS;
      m_uf    = 1'b0;
      m_ucnt  = 0;
      m_pix   = '0;
      m_fetch = 1'b1;
    end else begin
      m_pix = '0;
      if (rd) begin
        if (m_q.size() > 0) m_pix = ref_expand(m_q.pop_front());
        else begin
          m_uf = 1'b1;
          if (m_ucnt < 65535) m_ucnt++;
        end
      end
      if (exp_req && ack) begin
        m_q.push_back(rdata);
        m_addr = m_addr + 20'd1;
        m_rem--;
        if (m_rem == 0) m_fetch = 1'b0;
      end
    end
    if (!exp_req || ack) req_age = 0;
    else req_age++;
    if (exp_req && ack && rnd_wait) ack_wait = $urandom_range(0, 3);
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{16'hF800, 8'hFF, 8'h00, 8'h00};
    tbl[1] = '{16'h07E0, 8'h00, 8'hFF, 8'h00};
    tbl[2] = '{16'h001F, 8'h00, 8'h00, 8'hFF};
    tbl[3] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[4] = '{16'h8410, 8'h84, 8'h82, 8'h84};
    tbl[5] = '{16'h0841, 8'h08, 8'h08, 8'h08};
    exp_wrap = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};

    rst_n = 1'b0;
    i_sof = 1'b0; i_fb_base = '0; i_pix_rd = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    ack_wait = 0; rnd_wait = 1'b0; n_xfer = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_pix", 32'({o_pix_r, o_pix_g, o_pix_b}), 32'd0);
    chk("rst_underflow", 32'(o_underflow), 32'd0);
    chk("rst_fifo_count", 32'(dut.w_fifo_count), 32'd0);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 20'h0, 1'b0, 1'b0);

    // fill with one-cycle ack latency
    ack_wait = 1;
    cycle(1'b1, 20'h01000, 1'b0, 1'b0);
    chk("first_addr", 32'(o_mem_addr), 32'h01000);
    n_xfer = 0;
    repeat (40) cycle(1'b0, 20'h0, 1'b0, 1'b0);
    chk("fill_count", 32'(dut.w_fifo_count), 32'd16);
    chk("fill_req_drop", 32'(o_mem_req), 32'd0);
    chk("fill_xfers", 32'(n_xfer), 32'd16);

    // colour expansion table
    for (int i = 0; i < 6; i++) sram[20'h30000 + 20'(i)] = tbl[i].word;
    ack_wait = 0;
    cycle(1'b1, 20'h30000, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 20'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 20'h0, 1'b1, 1'b0);
      chk("tbl_pix", 32'({o_pix_r, o_pix_g, o_pix_b}), 32'({tbl[i].r, tbl[i].g, tbl[i].b}));
    end

    // 40-cycle ack stall with pix_rd held high
    ack_wait = 40;
    cycle(1'b1, 20'h40000, 1'b0, 1'b0);
    repeat (30) cycle(1'b0, 20'h0, 1'b1, 1'b0);
    chk("stall_underflow", 32'(o_underflow), 32'd1);
    chk("stall_pix", 32'({o_pix_r, o_pix_g, o_pix_b}), 32'd0);
    repeat (20) cycle(1'b0, 20'h0, 1'b1, 1'b0);
    ack_wait = 0;
    cycle(1'b1, 20'h40000, 1'b1, 1'b0);
    chk("sof_clears_uf", 32'(o_underflow), 32'd0);
    chk("sof_rd_pix", 32'({o_pix_r, o_pix_g, o_pix_b}), 32'd0);

    // whole frame, zero-wait ack, line-shaped reads
    cycle(1'b1, 20'h50000, 1'b0, 1'b0);
    n_xfer = 0;
    repeat (20) cycle(1'b0, 20'h0, 1'b0, 1'b0);
    for (int ln = 0; ln < V; ln++) begin
      repeat (H) cycle(1'b0, 20'h0, 1'b1, 1'b0);
      repeat (4) cycle(1'b0, 20'h0, 1'b0, 1'b0);
    end
    repeat (10) cycle(1'b0, 20'h0, 1'b0, 1'b0);
    chk("frame_xfers", 32'(n_xfer), 32'(WORDS));
    chk("frame_done", 32'(dut.r_state), 32'(ST_DONE));
    chk("frame_req", 32'(o_mem_req), 32'd0);
    chk("frame_uf", 32'(o_underflow), 32'd0);

    // ack coincident with sof is dropped
    ack_wait = 2;
    cycle(1'b1, 20'h60000, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 20'h0, 1'b0, 1'b0);
    cycle(1'b1, 20'h20000, 1'b0, 1'b1);
    chk("sofack_count", 32'(dut.w_fifo_count), 32'd0);
    chk("sofack_addr", 32'(o_mem_addr), 32'h20000);

    // address wrap
    ack_wait = 0;
    xfer_addr.delete();
    cycle(1'b1, 20'hFFFFE, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 20'h0, 1'b0, 1'b0);
    chk("wrap_n", 32'(xfer_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("wrap_addr", (i < xfer_addr.size()) ? 32'(xfer_addr[i]) : 32'hFFFFFFFF, 32'(exp_wrap[i]));

    // three pops on an empty FIFO
    ack_wait = 1000;
    cycle(1'b1, 20'h70000, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 20'h0, 1'b1, 1'b0);
    cycle(1'b0, 20'h0, 1'b0, 1'b0);
    chk("empty_pops_uf", 32'(o_underflow), 32'd1);
`ifdef VGA_FB_UNDERFLOW_CNT_EN
    chk("empty_pops_cnt", 32'(o_underflow_cnt), 32'd3);
`endif

    // reset with a request pending
    chk("pre_rst_req", 32'(o_mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(o_mem_req), 32'd0);
    chk("midrst_addr", 32'(o_mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ack_wait = 0;
    repeat (10) cycle(1'b0, 20'h0, 1'b0, 1'b0);

    // randomized traffic
    rnd_wait = 1'b1;
    ack_wait = $urandom_range(0, 3);
    cycle(1'b1, 20'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      bit sof, rd, af;
      sof = ($urandom_range(0, 299) == 0);
      rd  = ($urandom_range(0, 99) < 55);
      af  = sof && ($urandom_range(0, 1) == 1);
      cycle(sof, 20'($urandom), rd, af);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
